// File: rtl/pea_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pea_scheduler
// Description : Firing scheduler for the PEA actor: enable check, one-cycle
//               invoke, FC handshake, firing/stall statistics and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pea_scheduler #(
    parameter int buffer_size = 1024,
    parameter int timeout     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [$clog2(buffer_size):0]  command_pop,
    input  logic [$clog2(buffer_size):0]  data_pop,
    input  logic [$clog2(buffer_size):0]  result_free,
    input  logic [$clog2(buffer_size):0]  status_free,
    input  logic [1:0]                    mode_in,
    input  logic [3:0]                    N,
    input  logic [4:0]                    b,
    input  logic                          FC,
    output logic                          invoke,
    output logic [1:0]                    next_mode_out,
    output logic                          busy,
    output logic [15:0]                   fire_count,
    output logic [15:0]                   stall_count,
    output logic                          timeout_err
);

    localparam int c_CW = $clog2(buffer_size) + 1;
    localparam int c_WW = $clog2(timeout + 1);

    localparam logic [1:0] c_MODE_CMD = 2'b00;
    localparam logic [1:0] c_MODE_STP = 2'b01;
    localparam logic [1:0] c_MODE_EVP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_EVAL   = 3'd2,
        S_INVOKE = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_command_pop_q;
    logic [c_CW-1:0]   r_data_pop_q;
    logic [c_CW-1:0]   r_result_free_q;
    logic [c_CW-1:0]   r_status_free_q;
    logic [3:0]        r_n_q;
    logic [4:0]        r_b_q;
    logic [c_WW-1:0]   r_wd;
    logic              r_invoke;
    logic              r_busy;
    logic [1:0]        r_next_mode;
    logic [15:0]       r_fire_count;
    logic [15:0]       r_stall_count;
    logic              r_timeout_err;

    logic              w_enable;
    logic [c_CW-1:0]   w_n_plus1;
    logic [c_CW-1:0]   w_b_ext;

    // Enable is judged on the sampled copies so a firing sees settled counts.
    always_comb begin
        w_enable  = 1'b0;
        w_n_plus1 = c_CW'(r_n_q) + c_CW'(1);
        w_b_ext   = c_CW'(r_b_q);
        case (r_next_mode)
            c_MODE_CMD: w_enable = (r_command_pop_q != '0) && (r_status_free_q != '0)
                                   && (r_result_free_q != '0);
            c_MODE_STP: w_enable = (r_data_pop_q >= w_n_plus1) && (r_status_free_q != '0);
            c_MODE_EVP: begin
                if (r_b_q != '0)
                    w_enable = (r_data_pop_q >= w_b_ext) && (r_result_free_q >= w_b_ext);
                else
                    w_enable = (r_status_free_q != '0);
            end
            default:    w_enable = (r_status_free_q != '0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_command_pop_q <= '0;
            r_data_pop_q    <= '0;
            r_result_free_q <= '0;
            r_status_free_q <= '0;
            r_n_q           <= '0;
            r_b_q           <= '0;
            r_wd            <= '0;
            r_invoke        <= 1'b0;
            r_busy          <= 1'b0;
            r_next_mode     <= c_MODE_CMD;
            r_fire_count    <= '0;
            r_stall_count   <= '0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_command_pop_q <= command_pop;
            r_data_pop_q    <= data_pop;
            r_result_free_q <= result_free;
            r_status_free_q <= status_free;
            r_n_q           <= N;
            r_b_q           <= b;
            r_invoke        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (run && !r_timeout_err)
                        r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end else if (w_enable) begin
                        r_state  <= S_INVOKE;
                        r_invoke <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (r_stall_count != 16'hFFFF) begin
                        r_stall_count <= r_stall_count + 16'd1;
                    end
                end
                S_INVOKE: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (FC) begin
                        r_next_mode  <= mode_in;
                        r_fire_count <= r_fire_count + 16'd1;
                        r_busy       <= 1'b0;
                        r_state      <= run ? S_SETTLE : S_IDLE;
                    end else if (r_wd == c_WW'(timeout - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + c_WW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign invoke        = r_invoke;
    assign busy          = r_busy;
    assign next_mode_out = r_next_mode;
    assign fire_count    = r_fire_count;
    assign stall_count   = r_stall_count;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pea_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pea_scheduler
// Description : Directed self-checking bench for pea_scheduler (timeout=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pea_scheduler;

    logic        clk;
    logic        rst;
    logic        run;
    logic [10:0] command_pop;
    logic [10:0] data_pop;
    logic [10:0] result_free;
    logic [10:0] status_free;
    logic [1:0]  mode_in;
    logic [3:0]  N;
    logic [4:0]  b;
    logic        FC;
    logic        invoke;
    logic [1:0]  next_mode_out;
    logic        busy;
    logic [15:0] fire_count;
    logic [15:0] stall_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int inv_cnt = 0;

    pea_scheduler #(.buffer_size(1024), .timeout(16)) dut (
        .clk(clk), .rst(rst), .run(run),
        .command_pop(command_pop), .data_pop(data_pop),
        .result_free(result_free), .status_free(status_free),
        .mode_in(mode_in), .N(N), .b(b), .FC(FC),
        .invoke(invoke), .next_mode_out(next_mode_out), .busy(busy),
        .fire_count(fire_count), .stall_count(stall_count),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (invoke === 1'b1) inv_cnt++;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_invoke"}, 32'(invoke), 0);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_mode"},   32'(next_mode_out), 0);
        check({tag, "_fire"},   32'(fire_count), 0);
        check({tag, "_stall"},  32'(stall_count), 0);
        check({tag, "_err"},    32'(timeout_err), 0);
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; FC = 1'b0; mode_in = 2'b00;
        command_pop = 0; data_pop = 0; result_free = 0; status_free = 0;
        N = 0; b = 0;
        step(2);
        rst = 1'b1;
        step(1);
        check_reset_outputs("reset");

        // COMMAND firing: invoke 3 cycles after run
        command_pop = 1; result_free = 8; status_free = 8;
        step(2);
        run = 1'b1;
        step(1);
        check("cmd_settle_invoke", 32'(invoke), 0);
        step(1);
        check("cmd_eval_invoke", 32'(invoke), 0);
        step(1);
        check("cmd_invoke", 32'(invoke), 1);
        check("cmd_busy", 32'(busy), 1);
        step(1);
        check("cmd_wait_invoke", 32'(invoke), 0);
        check("cmd_wait_busy", 32'(busy), 1);
        FC = 1'b1; mode_in = 2'b01;
        N = 10; data_pop = 10;
        step(1);
        FC = 1'b0;
        check("cmd_next_mode", 32'(next_mode_out), 1);
        check("cmd_fire", 32'(fire_count), 1);
        check("cmd_busy_done", 32'(busy), 0);
        check("cmd_single_pulse", 32'(inv_cnt), 1);

        // STP: needs data_pop >= N+1
        step(5);
        check("stp_stall4", 32'(stall_count), 4);
        check("stp_no_invoke", 32'(inv_cnt), 1);
        data_pop = 11;
        step(1);
        check("stp_latency", 32'(invoke), 0);
        step(1);
        check("stp_invoke", 32'(invoke), 1);
        check("stp_stall5", 32'(stall_count), 5);
        step(1);
        FC = 1'b1; mode_in = 2'b10;
        b = 4; data_pop = 4; result_free = 3;
        step(1);
        FC = 1'b0;
        check("stp_fire", 32'(fire_count), 2);
        check("stp_next_mode", 32'(next_mode_out), 2);

        // EVP b=4, result_free short by one
        step(3);
        check("evp_stall7", 32'(stall_count), 7);
        check("evp_no_invoke", 32'(inv_cnt), 2);
        result_free = 4;
        step(2);
        check("evp_invoke", 32'(invoke), 1);
        check("evp_stall8", 32'(stall_count), 8);
        step(1);
        FC = 1'b1; mode_in = 2'b10;
        b = 0; status_free = 1; data_pop = 0; result_free = 0;
        step(1);
        FC = 1'b0;
        check("evp_fire", 32'(fire_count), 3);

        // EVP b=0 fires on status_free alone
        step(2);
        check("evp0_invoke", 32'(invoke), 1);
        check("evp0_stall", 32'(stall_count), 8);

        // run dropped during WAIT: firing completes, FSM parks
        step(1);
        run = 1'b0;
        FC = 1'b1; mode_in = 2'b11;
        step(1);
        FC = 1'b0;
        check("rundrop_fire", 32'(fire_count), 4);
        check("rundrop_mode", 32'(next_mode_out), 3);
        step(4);
        check("rundrop_no_invoke", 32'(inv_cnt), 4);
        check("rundrop_busy", 32'(busy), 0);

        // FC during EVAL is ignored (mode 11 stalled on status_free=0)
        status_free = 0;
        step(1);
        run = 1'b1;
        step(3);
        check("fceval_stall9", 32'(stall_count), 9);
        FC = 1'b1; mode_in = 2'b00;
        step(1);
        FC = 1'b0;
        check("fceval_fire", 32'(fire_count), 4);
        check("fceval_mode", 32'(next_mode_out), 3);
        check("fceval_stall10", 32'(stall_count), 10);

        // Watchdog: no FC after invoke
        status_free = 1;
        step(2);
        check("wd_invoke", 32'(invoke), 1);
        step(1);
        for (int i = 0; i < 15; i++) step(1);
        check("wd_not_yet", 32'(timeout_err), 0);
        check("wd_busy_still", 32'(busy), 1);
        step(1);
        check("wd_err", 32'(timeout_err), 1);
        check("wd_busy_clear", 32'(busy), 0);
        step(6);
        check("wd_blocked", 32'(inv_cnt), 5);
        check("wd_sticky", 32'(timeout_err), 1);

        // Reset mid-firing returns every output to reset values
        run = 1'b0;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check_reset_outputs("rst_clear");
        command_pop = 1; result_free = 8; status_free = 8; b = 0;
        step(2);
        run = 1'b1;
        step(4);
        FC = 1'b1; mode_in = 2'b10;
        step(1);
        FC = 1'b0;
        check("pre_rst_mode", 32'(next_mode_out), 2);
        check("pre_rst_fire", 32'(fire_count), 1);
        step(3);
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b0;
        step(1);
        check_reset_outputs("rst_wait");
        rst = 1'b1;
        run = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pea_scheduler.md
# pea_scheduler

Firing scheduler sitting directly upstream of the PEA top-level actor. It watches the four FIFO occupancy/vacancy counts and the actor's reported mode and arguments, decides when the actor is enabled, and issues a single-cycle `invoke`. It then waits for the firing-complete pulse `FC` and latches the actor's next mode. It also keeps firing and stall statistics and a watchdog on stuck firings.

## Interface
- `buffer_size`, 1024: words per FIFO. Count width `CW = clog2(buffer_size)+1` (11 at default).
- `timeout`, 1024: maximum cycles allowed in WAIT before the watchdog trips.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `run`  in  1  scheduler enable; low parks the FSM in IDLE after the current firing.
- `command_pop`  in  CW  Command Input FIFO population.
- `data_pop`  in  CW  Data Input FIFO population.
- `result_free`  in  CW  Result Output FIFO free words.
- `status_free`  in  CW  Status Output FIFO free words.
- `mode_in`  in  2  actor mode after the firing; valid when `FC`=1.
- `N`  in  4  degree argument from the actor.
- `b`  in  5  operation-count argument from the actor.
- `FC`  in  1  firing-complete pulse from the actor.
- `invoke`  out  1  one-cycle fire request.
- `next_mode_out`  out  2  mode driven to the actor's `next_mode_in`.
- `busy`  out  1  high in INVOKE and WAIT.
- `fire_count`  out  16  completed firings; wraps modulo 2^16.
- `stall_count`  out  16  EVAL cycles spent not enabled; saturates at 0xFFFF.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Modes:
  - 00 COMMAND
  - 01 STP (load coefficients)
  - 10 EVP (evaluate)
  - 11 RST/ERR
- Enable rule, computed from registered copies of the counts, `N` and `b` (`*_q`, sampled every cycle):
  - COMMAND: `command_pop_q≥1`, `status_free_q≥1` and `result_free_q≥1`.
  - STP: `data_pop_q ≥ N_q+1` and `status_free_q≥1`. Comparison is unsigned and zero-extended to CW.
  - EVP, `b_q≠0`: `data_pop_q ≥ b_q` and `result_free_q ≥ b_q`.
  - EVP, `b_q=0`: `status_free_q≥1` only.
  - RST/ERR: `status_free_q≥1`.
- FSM states:
  - IDLE: go to SETTLE when `run`=1 and `timeout_err`=0.
  - SETTLE: one cycle so the count registers reflect post-firing FIFO state; then go to EVAL.
  - EVAL:
    - `run`=0: go to IDLE.
    - enable=1: go to INVOKE.
    - otherwise stay in EVAL and increment `stall_count`.
  - INVOKE: `invoke`=1 for exactly one cycle, clear the watchdog counter, go to WAIT.
  - WAIT:
    - `FC`=1: `next_mode_out <= mode_in`, `fire_count++`, then go to SETTLE if `run`=1, else IDLE.
    - Watchdog counter reaches `timeout-1` with no `FC`: set `timeout_err`, go to IDLE.
- `timeout_err` blocks IDLE→SETTLE and is cleared only by `rst`.
- `FC` outside WAIT is ignored and does not touch the mode or counters.
- `run` falling during INVOKE or WAIT does not abort the firing.
- Reset values:
  - state IDLE.
  - `invoke`=0, `busy`=0.
  - `next_mode_out`=00 (COMMAND).
  - `fire_count`=0, `stall_count`=0, `timeout_err`=0.
  - all `*_q` registers 0.

## Timing
- All outputs are registered; `invoke` is decoded from state INVOKE.
- The count registers add one cycle of input latency.
- Best-case loop, FC to next invoke: FC seen in WAIT (cycle t), SETTLE at t+1, EVAL at t+2, INVOKE at t+3. Minimum invoke-to-invoke spacing is 4 cycles plus firing length.
- From IDLE with `run`=1 and enable already true, `invoke` is high 3 cycles after `run` is sampled.
- `next_mode_out` changes on the clock edge that leaves WAIT and is stable before the next `invoke`.
- `rst`=0 in any state, including mid-firing, returns every output to its reset value on the next edge.

## Test plan
- Reset, then `run`=1, mode 00, `command_pop`=1, free counts 8 → `invoke` pulses exactly once, 3 cycles after `run`. FC with `mode_in`=01 → `next_mode_out`=01, `fire_count`=1.
- STP with `N`=10, `data_pop`=10 for 5 cycles, then 11 → no `invoke` while `data_pop`=10 and `stall_count`≥4; `invoke` follows the step to 11.
- EVP with `b`=4, `data_pop`=4, `result_free`=3 → stalls; raising `result_free` to 4 → `invoke`. Also EVP with `b`=0 and `status_free`=1 → `invoke` immediately.
- `timeout`=16, no FC after invoke → `timeout_err`=1 after 16 WAIT cycles, FSM in IDLE, no further `invoke` despite `run`=1 and enable true.
- `run` dropped during WAIT, FC arrives → `fire_count` increments, FSM returns to IDLE, no new `invoke`. Also: FC pulse while in EVAL is ignored.
- `rst`=0 asserted in WAIT → all outputs at reset values on the next edge; `next_mode_out`=00.
